// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake and raw PS/2 line signals for the host transmitter
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    input  tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_dat_in,
    output tx_ready, tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_dat_oe
  );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain clock/data enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES    = 5000,
  parameter int START_HOLD_CYCLES = 100,
  parameter int TIMEOUT_CYCLES    = 750000
) (
  input  logic         clk,
  input  logic         resetn,
  ps2_host_tx_if.slave bus
);
  localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ?
    ((TIMEOUT_CYCLES > START_HOLD_CYCLES) ? TIMEOUT_CYCLES : START_HOLD_CYCLES) :
    ((INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [3:0] {
    S_IDLE, S_INHIBIT, S_START, S_RELEASE, S_DATA, S_ACK, S_WAIT_IDLE, S_DONE, S_ERROR
  } state_t;
  state_t          r_state, w_next;
  logic [1:0]      r_clk_s, r_dat_s;
  logic            r_clk_d;
  logic [9:0]      r_sh;
  logic [3:0]      r_n;
  logic [CW-1:0]   r_cnt;
  logic            w_clk, w_dat, w_fall, w_to_run, w_hold, w_timeout;
  logic [3:0]      w_idx;
  assign w_clk     = r_clk_s[1];
  assign w_dat     = r_dat_s[1];
  assign w_fall    = r_clk_d & ~w_clk;
  assign w_to_run  = r_state inside {S_RELEASE, S_DATA, S_ACK, S_WAIT_IDLE};
  assign w_hold    = r_state inside {S_INHIBIT, S_START};
  assign w_timeout = w_to_run && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign w_idx     = r_n - 4'd1;
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end
  // one counter times inhibit/start holds and device inactivity; any state change or device edge restarts it
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_clk_s <= 2'b11;
      r_dat_s <= 2'b11;
      r_clk_d <= 1'b1;
      r_sh    <= '0;
      r_n     <= '0;
      r_cnt   <= '0;
    end else begin
      r_clk_s <= {r_clk_s[0], bus.ps2_clk_in};
      r_dat_s <= {r_dat_s[0], bus.ps2_dat_in};
      r_clk_d <= w_clk;
      if (r_state == S_IDLE && bus.tx_valid) r_sh <= {1'b1, ~^bus.tx_data, bus.tx_data};
      r_n <= (r_state == S_IDLE) ? '0 :
             (w_fall && r_state inside {S_RELEASE, S_DATA}) ? r_n + 4'd1 : r_n;
      r_cnt <= (!(w_hold || w_to_run) || w_next != r_state || (w_fall && w_to_run)) ? '0 : r_cnt + CW'(1);
    end
  end
  always_comb begin
    w_next         = r_state;
    bus.tx_ready   = r_state == S_IDLE;
    bus.tx_busy    = r_state != S_IDLE;
    bus.tx_done    = r_state == S_DONE;
    bus.tx_error   = r_state == S_ERROR;
    bus.ps2_clk_oe = w_hold;
    bus.ps2_dat_oe = r_state inside {S_START, S_RELEASE} || (r_state == S_DATA && !r_sh[w_idx]);
    case (r_state)
      S_IDLE:      w_next = bus.tx_valid ? S_INHIBIT : S_IDLE;
      S_INHIBIT:   w_next = (r_cnt == CW'(INHIBIT_CYCLES - 1)) ? S_START : S_INHIBIT;
      S_START:     w_next = (r_cnt == CW'(START_HOLD_CYCLES - 1)) ? S_RELEASE : S_START;
      S_RELEASE:   w_next = w_fall ? S_DATA : (w_timeout ? S_ERROR : S_RELEASE);
      S_DATA:      w_next = w_fall ? ((r_n == 4'd9) ? S_ACK : S_DATA) : (w_timeout ? S_ERROR : S_DATA);
      S_ACK:       w_next = w_fall ? (w_dat ? S_ERROR : S_WAIT_IDLE) : (w_timeout ? S_ERROR : S_ACK);
      S_WAIT_IDLE: w_next = (w_clk && w_dat) ? S_DONE : (w_timeout ? S_ERROR : S_WAIT_IDLE);
      default:     w_next = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench with a clocking PS/2 device model on a wired-AND bus
module tb_ps2_host_tx;
  localparam int INH = 1000;
  localparam int STH = 100;
  localparam int TMO = 3000;
  localparam int H   = 20;
  typedef struct {
    bit         err;
    bit         has_bits;
    logic [7:0] d;
    bit         p;
  } exp_t;
  logic       clk = 1'b0;
  logic       resetn;
  logic       dev_clk, dev_dat;
  logic [7:0] cap_byte;
  logic       cap_par, cap_stop;
  int         n_vec = 0;
  int         n_err = 0;
  exp_t       q[$];
  ps2_host_tx_if bus ();
  assign bus.ps2_clk_in = dev_clk & ~bus.ps2_clk_oe;
  assign bus.ps2_dat_in = dev_dat & ~bus.ps2_dat_oe;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .START_HOLD_CYCLES(STH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask
  function automatic bit odd_par(input logic [7:0] d);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(d[i]);
    return (c % 2) == 0;
  endfunction
  function automatic exp_t mk(input logic [7:0] d, input int mode);
    exp_t e;
    e.err = mode != 0;
    e.has_bits = mode != 2;
    e.d = d;
    e.p = odd_par(d);
    return e;
  endfunction
  task automatic wait_ready();
    int w = 0;
    while (!bus.tx_ready && w < INH + STH + TMO + 2000) begin
      @(negedge clk);
      w++;
    end
    chk("ready_wait", bus.tx_ready, 1);
  endtask
  task automatic req(input logic [7:0] d);
    @(negedge clk);
    wait_ready();
    bus.tx_data = d;
    bus.tx_valid = 1'b1;
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
  endtask
  // mode 0: ACK, 1: no ACK, 2: silent device, 3: reset after the 5th falling edge
  task automatic dev(input int mode);
    int w;
    logic [10:0] b;
    b = '0;
    w = 0;
    while (!bus.ps2_clk_oe && w < 200) begin @(negedge clk); w++; end
    chk("inhibit_seen", bus.ps2_clk_oe, 1);
    w = 0;
    while (bus.ps2_clk_oe && w < INH + STH + 200) begin @(negedge clk); w++; end
    chk("clock_released", bus.ps2_clk_oe, 0);
    if (mode == 2) begin
      w = 0;
      while (!bus.tx_error && w < TMO + 50) begin @(negedge clk); w++; end
      chk("timeout_window", 32'(w >= TMO - 1 && w <= TMO + 1), 1);
      return;
    end
    repeat (5) @(negedge clk);
    for (int i = 1; i <= 11; i++) begin
      if (i == 11) begin
        dev_dat = (mode == 0) ? 1'b0 : 1'b1;
        repeat (H / 2) @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      b[i-1] = bus.ps2_dat_in;
      dev_clk = 1'b1;
      if (i == 10) begin
        cap_byte = b[7:0];
        cap_par  = b[8];
        cap_stop = b[9];
      end
      repeat (H) @(negedge clk);
      if (mode == 3 && i == 5) begin
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_clk_oe", bus.ps2_clk_oe, 0);
        chk("rst_mid_dat_oe", bus.ps2_dat_oe, 0);
        chk("rst_mid_ready", bus.tx_ready, 1);
        chk("rst_mid_pulses", {bus.tx_done, bus.tx_error}, 0);
        resetn = 1'b1;
        return;
      end
    end
    dev_dat = 1'b1;
  endtask
  task automatic xfer(input logic [7:0] d, input int mode);
    if (mode != 3) q.push_back(mk(d, mode));
    req(d);
    dev(mode);
    wait_ready();
  endtask
  initial begin : timing_mon
    int ph = 0;
    int len = 0;
    forever begin
      @(negedge clk);
      if (!resetn) ph = 0;
      else if (ph == 0) begin
        if (bus.ps2_clk_oe) begin
          chk("inhibit_dat_rel", bus.ps2_dat_oe, 0);
          ph = 1;
          len = 1;
        end
      end else if (ph == 1) begin
        if (bus.ps2_clk_oe && !bus.ps2_dat_oe) len++;
        else begin
          chk("inhibit_len", len, INH);
          ph = (bus.ps2_clk_oe && bus.ps2_dat_oe) ? 2 : 0;
          len = 1;
        end
      end else if (bus.ps2_clk_oe && bus.ps2_dat_oe) len++;
      else begin
        chk("start_len", len, STH);
        chk("release_dat_low", bus.ps2_dat_oe, 1);
        ph = 0;
      end
    end
  end
  initial begin : pulse_mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && (bus.tx_done || bus.tx_error)) begin
        chk("done_err_exclusive", 32'(bus.tx_done & bus.tx_error), 0);
        chk("lines_released", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        chk("busy_in_pulse", bus.tx_busy, 1);
        if (q.size() == 0) chk("unexpected_pulse", {bus.tx_done, bus.tx_error}, 0);
        else begin
          e = q.pop_front();
          chk("outcome_error", bus.tx_error, e.err);
          if (e.has_bits) begin
            chk("sent_byte", cap_byte, e.d);
            chk("sent_parity", cap_par, e.p);
            chk("sent_stop", cap_stop, 1);
          end
        end
        @(negedge clk);
        chk("single_pulse", {bus.tx_done, bus.tx_error}, 0);
        chk("ready_after", bus.tx_ready, 1);
        chk("busy_after", bus.tx_busy, 0);
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] a, b;
    resetn = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_busy", bus.tx_busy, 0);
    chk("rst_pulses", {bus.tx_done, bus.tx_error}, 0);
    chk("rst_lines", {bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
    resetn = 1'b1;
    xfer(8'hF4, 0);
    xfer(8'hFF, 0);
    xfer(8'h00, 0);
    xfer(8'($urandom_range(0, 255)), 1);
    xfer(8'($urandom_range(0, 255)), 2);
    xfer(8'($urandom_range(0, 255)), 3);
    xfer(8'hAA, 0);
    a = 8'($urandom_range(0, 255));
    b = ~a;
    q.push_back(mk(a, 0));
    q.push_back(mk(b, 0));
    req(a);
    bus.tx_valid = 1'b1;
    #1 bus.tx_data = b;
    dev(0);
    wait_ready();
    @(posedge clk);
    #1 bus.tx_valid = 1'b0;
    dev(0);
    wait_ready();
    for (int k = 0; k < 4; k++) xfer(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0) ? 1 : 0);
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: the send side of the PS/2 link that the drawing grid currently only receives on.
- Sends command bytes to the keyboard or mouse, e.g. 0xF4 (enable reporting) and 0xFF (reset).
- Drives PS2_CLK/PS2_DAT through open-drain enables at top level, on CLOCK_50.
- Asserts tx_busy so the PS/2 receiver ignores bus activity during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000, clock-low inhibit duration in clk cycles (100 us at 50 MHz).
- START_HOLD_CYCLES, 100, cycles data is held low before clock is released.
- TIMEOUT_CYCLES, 750000, max clk cycles between device events before abort (15 ms).

Ports:
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  synchronous active-low reset
- tx_data  in  8  command byte
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx_busy  out  1  high in every non-IDLE state
- tx_done  out  1  one-cycle pulse, byte sent and ACK received
- tx_error  out  1  one-cycle pulse, timeout or missing ACK
- ps2_clk_in  in  1  raw PS2_CLK line level
- ps2_dat_in  in  1  raw PS2_DAT line level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release

Behaviour:
- Reset (resetn=0 at a clk edge):
  - State IDLE; tx_ready=1; all other outputs 0 (both lines released).
  - Synchronizers preset to 1; counters cleared.
  - Reset mid-transfer releases both lines on the next cycle; no done/error pulse.
- Inputs: ps2_clk_in and ps2_dat_in each pass through a 2-flop synchronizer.
  - Falling edge of PS2_CLK = synced previous 1, synced current 0.
  - All bus decisions use synced values (2-3 cycle input latency).
- Accept: in IDLE with tx_valid=1.
  - Latch shift register = {stop=1, parity, tx_data}.
  - Parity is odd: parity = ~^tx_data.
  - Next cycle enter INHIBIT, tx_ready=0.
  - tx_valid in any other state is ignored.
- INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES cycles.
- START: clk_oe=1, dat_oe=1 (start bit) for START_HOLD_CYCLES cycles.
- RELEASE: clk_oe=0, dat_oe=1. Bit counter n=0; timeout counter cleared.
- DATA, on each PS2_CLK falling edge n increments, then:
  - n=1..8: dat_oe = ~tx_data[n-1] (LSB first).
  - n=9: dat_oe = ~parity.
  - n=10: dat_oe=0 (stop bit, line released); enter ACK.
  - dat_oe changes within 1 cycle of the detected edge; it is stable otherwise.
- ACK: on the next falling edge (11th), sample synced data.
  - 0 -> WAIT_IDLE.
  - 1 -> ERROR (no ACK).
- WAIT_IDLE: wait until synced clk=1 and data=1, then DONE.
- DONE: tx_done=1 for one cycle -> IDLE.
- ERROR: tx_error=1 for one cycle, both lines released -> IDLE.
- Timeout:
  - Counter runs in RELEASE, DATA, ACK and WAIT_IDLE.
  - Cleared on entry to each of those states and on every PS2_CLK falling edge.
  - Reaching TIMEOUT_CYCLES -> ERROR.
- tx_done and tx_error are never high in the same cycle; tx_ready returns the cycle after either pulse.
- Bus contention: a device falling edge during INHIBIT or START is ignored; the host holds the clock.
- Counter widths: sized by $clog2 of the largest parameter; no wrap before terminal count.

Test Plan:
- 0xF4 with a responsive device model that ACKs:
  - clk_oe low for 5000 cycles, then data low 100 cycles before clock release.
  - Sampled bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
  - tx_done pulses once; tx_busy falls with it.
- 0xFF and 0x00: parity bit on the 9th falling edge = 1 for both; ACK -> tx_done.
- Device holds data high at the 11th falling edge -> tx_error single pulse, tx_done stays 0, lines released.
- Device never clocks after release -> tx_error exactly TIMEOUT_CYCLES cycles (plus/minus 1) after entering RELEASE.
- resetn=0 after the 5th falling edge:
  - Next cycle clk_oe=0, dat_oe=0, tx_ready=1, no pulses.
  - A new request for 0xAA then completes correctly.
- tx_valid held high with a new tx_data during a transfer: the byte on the bus is unchanged; the second byte starts only after tx_done.
